// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, drives the ROM address and
// loads the IF/ID register, resolving stalls and branch redirects.
module fetch_stage #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] rom_instr,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_pc,
  output logic [PC_WIDTH-1:0]    rom_addr,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc,
  output logic                   ifid_valid,
  output logic                   redirect_pending,
  output logic [31:0]            fetch_count
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic                   valid;
  } if_id_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam if_id_t BUBBLE = '{
    instr: NOP_INSTR,
    pc:    '0,
    valid: 1'b0
  };

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pend_pc;
  logic [31:0]         count;
  if_id_t              ifid;
  state_t              state;

  logic sel_hold;
  logic sel_branch;
  logic sel_pend;

  // Mutually exclusive selects so the decoder below is truly unique.
  always_comb begin
    sel_hold   = stall;
    sel_branch = !stall && branch_taken;
    sel_pend   = !stall && !branch_taken
                 && (state == PENDING);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      pend_pc <= '0;
      count   <= '0;
      ifid    <= BUBBLE;
      state   <= IDLE;
    end else begin
      unique case (1'b1)
        sel_hold: begin
          if (branch_taken) begin
            pend_pc <= branch_pc;
            state   <= PENDING;
          end
        end
        sel_branch: begin
          pc    <= branch_pc;
          ifid  <= BUBBLE;
          state <= IDLE;
        end
        sel_pend: begin
          pc    <= pend_pc;
          ifid  <= BUBBLE;
          state <= IDLE;
        end
        default: begin
          ifid.instr <= rom_instr;
          ifid.pc    <= pc;
          ifid.valid <= 1'b1;
          pc         <= pc + PC_WIDTH'(1);
          count      <= count + 32'd1;
        end
      endcase
    end
  end

  assign rom_addr         = pc;
  assign ifid_instr       = ifid.instr;
  assign ifid_pc          = ifid.pc;
  assign ifid_valid       = ifid.valid;
  assign redirect_pending = (state == PENDING);
  assign fetch_count      = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: ROM word n = 0x1000+n,
// outputs sampled 1ns after each rising edge.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [31:0] rom_instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] rom_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        redirect_pending;
  logic [31:0] fetch_count;

  int tests;
  int fails;

  fetch_stage dut (
    .clock            (clock),
    .reset            (reset),
    .rom_instr        (rom_instr),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_pc        (branch_pc),
    .rom_addr         (rom_addr),
    .ifid_instr       (ifid_instr),
    .ifid_pc          (ifid_pc),
    .ifid_valid       (ifid_valid),
    .redirect_pending (redirect_pending),
    .fetch_count      (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign rom_instr = 32'h1000 + rom_addr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".addr"}, rom_addr, 32'h0);
    chk({tag, ".instr"}, ifid_instr, 32'h0);
    chk({tag, ".pc"}, ifid_pc, 32'h0);
    chk({tag, ".valid"}, {31'b0, ifid_valid}, 32'h0);
    chk({tag, ".pend"}, {31'b0, redirect_pending}, 32'h0);
    chk({tag, ".count"}, fetch_count, 32'h0);
  endtask

  task automatic chk_fetch(input string tag,
                           input logic [31:0] addr,
                           input logic [31:0] instr,
                           input logic [31:0] pc,
                           input logic        valid,
                           input logic [31:0] count);
    chk({tag, ".addr"}, rom_addr, addr);
    chk({tag, ".instr"}, ifid_instr, instr);
    chk({tag, ".pc"}, ifid_pc, pc);
    chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, valid});
    chk({tag, ".count"}, fetch_count, count);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_pc = 32'h0;

    tick();
    tick();
    chk_reset("rst");

    reset = 1'b1;
    tick();
    chk_fetch("run0", 32'h1, 32'h1000, 32'h0, 1'b1, 32'd1);
    tick();
    chk_fetch("run1", 32'h2, 32'h1001, 32'h1, 1'b1, 32'd2);
    tick();
    chk_fetch("run2", 32'h3, 32'h1002, 32'h2, 1'b1, 32'd3);
    tick();
    tick();
    chk_fetch("run4", 32'h5, 32'h1004, 32'h4, 1'b1, 32'd5);

    stall = 1'b1;
    tick();
    chk_fetch("stl0", 32'h5, 32'h1004, 32'h4, 1'b1, 32'd5);
    tick();
    chk_fetch("stl1", 32'h5, 32'h1004, 32'h4, 1'b1, 32'd5);
    stall = 1'b0;
    tick();
    chk_fetch("stlr", 32'h6, 32'h1005, 32'h5, 1'b1, 32'd6);
    tick();
    chk_fetch("pre", 32'h7, 32'h1006, 32'h6, 1'b1, 32'd7);

    branch_taken = 1'b1;
    branch_pc = 32'h20;
    tick();
    chk_fetch("br", 32'h20, 32'h0, 32'h0, 1'b0, 32'd7);
    branch_taken = 1'b0;
    tick();
    chk_fetch("brt", 32'h21, 32'h1020, 32'h20, 1'b1, 32'd8);

    stall = 1'b1;
    branch_taken = 1'b1;
    branch_pc = 32'h40;
    tick();
    chk("sb0.pend", {31'b0, redirect_pending}, 32'h1);
    chk("sb0.addr", rom_addr, 32'h21);
    branch_pc = 32'h44;
    tick();
    chk("sb1.pend", {31'b0, redirect_pending}, 32'h1);
    branch_taken = 1'b0;
    tick();
    chk_fetch("sb2", 32'h21, 32'h1020, 32'h20, 1'b1, 32'd8);
    chk("sb2.pend", {31'b0, redirect_pending}, 32'h1);
    stall = 1'b0;
    tick();
    chk_fetch("sbr", 32'h44, 32'h0, 32'h0, 1'b0, 32'd8);
    chk("sbr.pend", {31'b0, redirect_pending}, 32'h0);
    tick();
    chk_fetch("sbt", 32'h45, 32'h1044, 32'h44, 1'b1, 32'd9);

    stall = 1'b1;
    branch_taken = 1'b1;
    branch_pc = 32'h48;
    tick();
    chk("lv0.pend", {31'b0, redirect_pending}, 32'h1);
    stall = 1'b0;
    branch_pc = 32'h50;
    tick();
    chk_fetch("lv1", 32'h50, 32'h0, 32'h0, 1'b0, 32'd9);
    chk("lv1.pend", {31'b0, redirect_pending}, 32'h0);
    branch_taken = 1'b0;
    tick();
    chk_fetch("lvt", 32'h51, 32'h1050, 32'h50, 1'b1, 32'd10);

    branch_taken = 1'b1;
    branch_pc = 32'hFFFF_FFFF;
    tick();
    chk("wr0.addr", rom_addr, 32'hFFFF_FFFF);
    branch_taken = 1'b0;
    tick();
    chk_fetch("wr1", 32'h0, 32'h0000_0FFF, 32'hFFFF_FFFF,
              1'b1, 32'd11);

    stall = 1'b1;
    branch_taken = 1'b1;
    branch_pc = 32'h80;
    tick();
    chk("ar0.pend", {31'b0, redirect_pending}, 32'h1);
    branch_taken = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset("arst");
    stall = 1'b0;
    reset = 1'b1;
    tick();
    chk_fetch("ar1", 32'h1, 32'h1000, 32'h0, 1'b1, 32'd1);
    chk("ar1.pend", {31'b0, redirect_pending}, 32'h0);
    tick();
    chk_fetch("ar2", 32'h2, 32'h1001, 32'h1, 1'b1, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
